// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine sequencer.
// FSM encoding, coin values, one-hot change codes and BCD conversion.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    localparam logic [6:0] COIN_1 = 7'd1;
    localparam logic [6:0] COIN_2 = 7'd2;
    localparam logic [6:0] COIN_5 = 7'd5;

    localparam logic [2:0] OUT_NONE = 3'b000;
    localparam logic [2:0] OUT_1    = 3'b001;
    localparam logic [2:0] OUT_2    = 3'b010;
    localparam logic [2:0] OUT_5    = 3'b100;

    // Repeated subtraction keeps this a small constant-bound loop.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/vend_change_disp.sv
// Change dispenser: paces coin_out pulses and picks the largest coin
// that fits the remaining amount.
module vend_change_disp
    import vend_pkg::*;
#(
    parameter int CHANGE_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] amount,
    output logic [2:0] coin_out,
    output logic [6:0] take,
    output logic       done
);

    localparam int GW =
        (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CHANGE_GAP - 1);

    logic [GW-1:0] gap_q;
    logic [2:0]    code;
    logic          fire;

    assign fire = start && (gap_q == '0) && (amount != '0);
    assign done = (amount == '0);

    always_comb begin
        code = OUT_NONE;
        take = '0;
        if (fire) begin
            if (amount >= COIN_5) begin
                code = OUT_5;
                take = COIN_5;
            end else if (amount >= COIN_2) begin
                code = OUT_2;
                take = COIN_2;
            end else begin
                code = OUT_1;
                take = COIN_1;
            end
        end
    end

    // Gap counter idles at zero so the first pulse lands immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_q    <= '0;
            coin_out <= OUT_NONE;
        end else begin
            coin_out <= code;
            if (!start)
                gap_q <= '0;
            else if (fire)
                gap_q <= GAP_LAST;
            else if (gap_q != '0)
                gap_q <= gap_q - GW'(1);
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine sequencer: coin edge detect, credit, vend strobe
// and hand-off of change to the dispenser.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE       = 15,
    parameter int VEND_CYCLES = 4,
    parameter int CHANGE_GAP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r1,
    input  logic       r2,
    input  logic       r5,
    input  logic       cancel,
    output logic [7:0] credit_bcd,
    output logic       vend,
    output logic [2:0] coin_out,
    output logic       reject,
    output logic       busy,
    output logic [1:0] state
);

    localparam int VW =
        (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
    localparam logic [6:0]    PRICE_V   = 7'(PRICE);
    localparam logic [VW-1:0] VEND_LAST = VW'(VEND_CYCLES - 1);

    state_t        state_q, state_d;
    logic [6:0]    credit_q, credit_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          vend_q, vend_d;
    logic          reject_q, reject_d;
    logic          r1_q, r2_q, r5_q;
    logic [6:0]    rise_sum, credit_sum, take;
    logic          any_rise, chg_done, in_change;

    assign rise_sum =
        ((r1 & ~r1_q) ? COIN_1 : 7'd0) +
        ((r2 & ~r2_q) ? COIN_2 : 7'd0) +
        ((r5 & ~r5_q) ? COIN_5 : 7'd0);
    assign any_rise   = (rise_sum != 7'd0);
    assign credit_sum = credit_q + rise_sum;
    assign in_change  = (state_q == S_CHANGE);

    vend_change_disp #(
        .CHANGE_GAP(CHANGE_GAP)
    ) u_chg (
        .clk     (clk),
        .reset   (reset),
        .start   (in_change),
        .amount  (credit_q),
        .coin_out(coin_out),
        .take    (take),
        .done    (chg_done)
    );

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        vcnt_d   = vcnt_q;
        vend_d   = vend_q;
        reject_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_COLLECT: begin
                credit_d = credit_sum;
                // Reaching the price wins over a same-cycle cancel.
                if (credit_sum >= PRICE_V) begin
                    state_d = S_VEND;
                    vend_d  = 1'b1;
                    vcnt_d  = VEND_LAST;
                end else if (cancel && credit_sum != '0) begin
                    state_d = S_CHANGE;
                end else if (credit_sum != '0) begin
                    state_d = S_COLLECT;
                end
            end
            S_VEND: begin
                reject_d = any_rise;
                if (vcnt_q == '0) begin
                    vend_d   = 1'b0;
                    credit_d = credit_q - PRICE_V;
                    state_d  = (credit_q == PRICE_V) ? S_IDLE
                                                     : S_CHANGE;
                end else begin
                    vcnt_d = vcnt_q - VW'(1);
                end
            end
            S_CHANGE: begin
                reject_d = any_rise;
                credit_d = credit_q - take;
                if (chg_done)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            vcnt_q   <= '0;
            vend_q   <= 1'b0;
            reject_q <= 1'b0;
            r1_q     <= 1'b0;
            r2_q     <= 1'b0;
            r5_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            vcnt_q   <= vcnt_d;
            vend_q   <= vend_d;
            reject_q <= reject_d;
            r1_q     <= r1;
            r2_q     <= r2;
            r5_q     <= r5;
        end
    end

    assign credit_bcd = bin2bcd(credit_q);
    assign vend       = vend_q;
    assign reject     = reject_q;
    assign state      = state_q;
    assign busy       = (state_q == S_VEND) ||
                        (state_q == S_CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: vector table, corner sequences and random
// stimulus against a transaction-level reference model.
module tb_vend_ctrl;

    localparam int PRICE       = 15;
    localparam int VEND_CYCLES = 4;
    localparam int CHANGE_GAP  = 2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       r1     = 1'b0;
    logic       r2     = 1'b0;
    logic       r5     = 1'b0;
    logic       cancel = 1'b0;
    logic [7:0] credit_bcd;
    logic       vend;
    logic [2:0] coin_out;
    logic       reject;
    logic       busy;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    vend_ctrl #(
        .PRICE      (PRICE),
        .VEND_CYCLES(VEND_CYCLES),
        .CHANGE_GAP (CHANGE_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r1        (r1),
        .r2        (r2),
        .r5        (r5),
        .cancel    (cancel),
        .credit_bcd(credit_bcd),
        .vend      (vend),
        .coin_out  (coin_out),
        .reject    (reject),
        .busy      (busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Reference model: phase, credit, vend countdown, change queue.
    int   m_state;
    int   m_credit;
    int   m_vend_left;
    int   m_wait;
    int   m_coin;
    int   m_reject;
    int   m_q[$];
    logic p1, p2, p5;

    function automatic void model_reset();
        m_state     = 0;
        m_credit    = 0;
        m_vend_left = 0;
        m_wait      = 0;
        m_coin      = 0;
        m_reject    = 0;
        m_q.delete();
        p1 = 1'b0;
        p2 = 1'b0;
        p5 = 1'b0;
    endfunction

    function automatic void load_change(input int c);
        m_q.delete();
        repeat (c / 5) m_q.push_back(5);
        repeat ((c % 5) / 2) m_q.push_back(2);
        repeat ((c % 5) % 2) m_q.push_back(1);
        m_wait = 0;
    endfunction

    function automatic void model_step();
        int sum;
        if (!reset) begin
            model_reset();
            return;
        end
        sum = ((r1 && !p1) ? 1 : 0) + ((r2 && !p2) ? 2 : 0) +
              ((r5 && !p5) ? 5 : 0);
        p1 = r1;
        p2 = r2;
        p5 = r5;
        m_coin   = 0;
        m_reject = 0;
        case (m_state)
            0, 1: begin
                m_credit = m_credit + sum;
                if (m_credit >= PRICE) begin
                    m_state     = 2;
                    m_vend_left = VEND_CYCLES;
                end else if (cancel && m_credit > 0) begin
                    m_state = 3;
                    load_change(m_credit);
                end else if (m_credit > 0) begin
                    m_state = 1;
                end
            end
            2: begin
                m_reject    = (sum > 0) ? 1 : 0;
                m_vend_left = m_vend_left - 1;
                if (m_vend_left == 0) begin
                    m_credit = m_credit - PRICE;
                    if (m_credit == 0) begin
                        m_state = 0;
                    end else begin
                        m_state = 3;
                        load_change(m_credit);
                    end
                end
            end
            default: begin
                m_reject = (sum > 0) ? 1 : 0;
                if (m_credit == 0) begin
                    m_state = 0;
                end else if (m_wait == 0) begin
                    m_coin   = m_q.pop_front();
                    m_credit = m_credit - m_coin;
                    m_wait   = CHANGE_GAP - 1;
                end else begin
                    m_wait = m_wait - 1;
                end
            end
        endcase
    endfunction

    function automatic logic [15:0] model_out();
        logic [7:0] bcd;
        logic [2:0] oh;
        bcd = {4'(m_credit / 10), 4'(m_credit % 10)};
        oh  = (m_coin == 5) ? 3'b100 :
              (m_coin == 2) ? 3'b010 :
              (m_coin == 1) ? 3'b001 : 3'b000;
        return {bcd, (m_state == 2), oh, m_reject[0],
                (m_state >= 2), 2'(m_state)};
    endfunction

    function automatic logic [15:0] dut_out();
        return {credit_bcd, vend, coin_out, reject, busy, state};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model", 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic hit(input int w);
        r1 = (w == 1);
        r2 = (w == 2);
        r5 = (w == 5);
        step();
        r1 = 1'b0;
        r2 = 1'b0;
        r5 = 1'b0;
    endtask

    typedef struct {
        logic       r1, r2, r5, cancel;
        logic [7:0] bcd;
        logic [1:0] st;
        logic       vend;
        logic [2:0] coin;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int vcyc, npulse, nrej;
        logic [2:0] lastp;
        logic [7:0] chg_bcd;
        bit seen;

        tbl[0]  = '{0, 0, 1, 0, 8'h05, 2'd1, 0, 3'b000};
        tbl[1]  = '{0, 0, 0, 0, 8'h05, 2'd1, 0, 3'b000};
        tbl[2]  = '{0, 0, 1, 0, 8'h10, 2'd1, 0, 3'b000};
        tbl[3]  = '{0, 0, 0, 0, 8'h10, 2'd1, 0, 3'b000};
        tbl[4]  = '{0, 0, 1, 0, 8'h15, 2'd2, 1, 3'b000};
        tbl[5]  = '{0, 0, 0, 0, 8'h15, 2'd2, 1, 3'b000};
        tbl[6]  = '{0, 0, 0, 0, 8'h15, 2'd2, 1, 3'b000};
        tbl[7]  = '{0, 0, 0, 0, 8'h15, 2'd2, 1, 3'b000};
        tbl[8]  = '{0, 0, 0, 0, 8'h00, 2'd0, 0, 3'b000};
        tbl[9]  = '{0, 0, 0, 0, 8'h00, 2'd0, 0, 3'b000};
        tbl[10] = '{1, 1, 1, 0, 8'h08, 2'd1, 0, 3'b000};
        tbl[11] = '{0, 0, 0, 1, 8'h08, 2'd3, 0, 3'b000};
        tbl[12] = '{0, 0, 0, 0, 8'h03, 2'd3, 0, 3'b100};
        tbl[13] = '{0, 0, 0, 0, 8'h03, 2'd3, 0, 3'b000};
        tbl[14] = '{0, 0, 0, 0, 8'h01, 2'd3, 0, 3'b010};
        tbl[15] = '{0, 0, 0, 0, 8'h01, 2'd3, 0, 3'b000};
        tbl[16] = '{0, 0, 0, 0, 8'h00, 2'd3, 0, 3'b001};
        tbl[17] = '{0, 0, 0, 0, 8'h00, 2'd0, 0, 3'b000};

        model_reset();

        // Reset with clock running, then release.
        repeat (2) @(negedge clk);
        chk("reset_out", 32'(dut_out()), 32'h0);
        reset = 1'b1;
        idle(2);
        chk("post_reset", 32'(dut_out()), 32'h0);

        // Vector table: three r5 vend, then 8 rupees refunded.
        for (int i = 0; i < 18; i++) begin
            r1     = tbl[i].r1;
            r2     = tbl[i].r2;
            r5     = tbl[i].r5;
            cancel = tbl[i].cancel;
            step();
            chk($sformatf("tbl%0d", i),
                {credit_bcd, state, vend, coin_out},
                {tbl[i].bcd, tbl[i].st, tbl[i].vend, tbl[i].coin});
        end
        cancel = 1'b0;

        // 5+5+2+5 = 17: vend then a single 2-rupee coin.
        hit(5); idle(1); hit(5); idle(1); hit(2); idle(1); hit(5);
        chk("s3_vend_entry", {credit_bcd, state}, {8'h17, 2'd2});
        vcyc = 1; npulse = 0; lastp = '0; seen = 0; chg_bcd = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (vend) vcyc++;
            if (coin_out != 3'b000) begin
                npulse++;
                lastp = coin_out;
            end
            if (state == 2'd3 && !seen) begin
                seen    = 1;
                chg_bcd = credit_bcd;
            end
        end
        chk("s3_vend_len", vcyc, VEND_CYCLES);
        chk("s3_npulse", npulse, 1);
        chk("s3_coin", lastp, 3'b010);
        chk("s3_change_amt", chg_bcd, 8'h02);
        chk("s3_end", {credit_bcd, state}, {8'h00, 2'd0});

        // Coin during VEND is rejected; held coin not counted later.
        hit(5); idle(1); hit(5); idle(1); hit(2); idle(1); hit(5);
        idle(1);
        r5 = 1'b1;
        nrej = 0; seen = 0; chg_bcd = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (reject) nrej++;
            if (state == 2'd3 && !seen) begin
                seen    = 1;
                chg_bcd = credit_bcd;
            end
        end
        chk("s5_reject", nrej, 1);
        chk("s5_change_amt", chg_bcd, 8'h02);
        chk("s5_held_coin", {credit_bcd, state}, {8'h00, 2'd0});
        r5 = 1'b0;
        idle(1);

        // Price completed with cancel high: vend wins.
        hit(5); idle(1); hit(5); idle(1);
        r5 = 1'b1; cancel = 1'b1;
        step();
        r5 = 1'b0; cancel = 1'b0;
        chk("s5_cancel_prio", {state, vend}, {2'd2, 1'b1});
        idle(10);
        chk("s5_cancel_end", {credit_bcd, state}, {8'h00, 2'd0});

        // Reset between change pulses.
        r1 = 1'b1; r2 = 1'b1; r5 = 1'b1;
        step();
        r1 = 1'b0; r2 = 1'b0; r5 = 1'b0; cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();
        chk("s6_first", {coin_out, credit_bcd}, {3'b100, 8'h03});
        reset = 1'b0;
        model_reset();
        #1;
        chk("s6_async", 32'(dut_out()), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s6_no_pulse", coin_out, 3'b000);
        end
        reset = 1'b1;
        r1 = 1'b1;
        step();
        r1 = 1'b0;
        chk("s6_new_coin", {credit_bcd, state}, {8'h01, 2'd1});
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        idle(4);

        // Coin high as reset releases counts as a rise.
        reset = 1'b0;
        model_reset();
        r2 = 1'b1;
        step();
        reset = 1'b1;
        step();
        r2 = 1'b0;
        chk("s7_rel_rise", credit_bcd, 8'h02);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        idle(4);
        chk("s7_end", state, 2'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r1     = ($urandom_range(0, 3) == 0);
            r2     = ($urandom_range(0, 3) == 0);
            r5     = ($urandom_range(0, 3) == 0);
            cancel = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                chk("rand_reset", 32'(dut_out()), 32'h0);
            end
            step();
            reset = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Vending-machine sequencer that sits between the coin inputs (r1, r2, r5) and the seg_7 display/LED block. It accumulates inserted coins as credit, triggers a vend when the credit reaches the price, and returns change one coin at a time using greedy 5/2/1 selection. It presents credit to the display as two BCD digits. Coin inputs arrive already synchronised and debounced to clk; this block only edge-detects them.

## Interface
- PRICE, 15: item price in rupees; legal range 1..90.
- VEND_CYCLES, 4: number of cycles vend is held high; must be ≥1.
- CHANGE_GAP, 2: number of cycles between successive coin_out pulses; must be ≥1.
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- r1 / r2 / r5  in  1 each  coin-present levels; a 0→1 transition deposits 1 / 2 / 5 rupees.
- cancel  in  1  level; requests a refund of the current credit.
- credit_bcd  out  8  {tens, ones} BCD of the current credit or remaining change.
- vend  out  1  item-release strobe (drives led_M5).
- coin_out  out  3  one-hot change pulse: [2]=5, [1]=2, [0]=1 rupee.
- reject  out  1  one-cycle pulse when a coin edge is ignored.
- busy  out  1  high in VEND or CHANGE.
- state  out  2  encoded FSM state, for debug.

## Operation
- **FSM states:** IDLE=0, COLLECT=1, VEND=2, CHANGE=3. Internal credit is a 7-bit binary register; credit_bcd is its combinational BCD conversion.
- **Edge detection:** each coin input has a previous-value register. A rise is `rX & ~rX_q`. All rises seen in one cycle are summed, so r1+r2+r5 together deposit 8.
- **IDLE / COLLECT:**
  - On any rise, credit_next = credit + sum.
  - If credit_next ≥ PRICE → VEND (this has priority over cancel).
  - Else if cancel and credit_next > 0 → CHANGE.
  - Else if credit_next > 0 → COLLECT.
  - cancel in IDLE with no coin is ignored.
- **Credit bound:** credit never exceeds PRICE-1+8 ≤ 97, so no saturation logic is required.
- **VEND:**
  - vend is high for exactly VEND_CYCLES cycles.
  - On exit, credit ← credit − PRICE (range 0..7).
  - If the result is 0 → IDLE; else → CHANGE.
- **CHANGE:**
  - Every CHANGE_GAP cycles, emit one coin_out pulse for the largest coin ≤ credit, and subtract that coin from credit in the same cycle.
  - The first pulse occurs in the first CHANGE cycle.
  - When credit reaches 0 → IDLE.
- **Coins while busy:** any coin rise during VEND or CHANGE raises reject for 1 cycle and leaves credit unchanged. Edge registers still track the inputs, so a coin held across the return to IDLE is not counted.
- **Reset values:** state=IDLE, credit=0, credit_bcd=8'h00, vend=0, coin_out=0, reject=0, busy=0. Edge registers clear to 0, so a coin input that is high when reset releases counts as a rise on the first edge.
- **Reset mid-operation** abandons the vend or refund with no further pulses.

## Timing
- Coin-to-credit latency: credit_bcd updates at the same edge where the rise is first sampled.
- The transition into VEND happens on the same edge as the credit update. vend is registered high from that edge and low after VEND_CYCLES edges.
- In CHANGE, coin_out is registered and high for 1 cycle. Pulses are spaced CHANGE_GAP cycles apart, and credit decrements on the same edge as each pulse.
- All outputs are registered except credit_bcd, which is combinational from the credit register.

## Structure
- **Package vend_pkg** holds:
  - the state enum and encodings;
  - the coin value constants 1/2/5;
  - the one-hot coin_out codes;
  - the function bin2bcd(7-bit → 8-bit).
- **Sub-module vend_change_disp** owns the CHANGE_GAP counter and the greedy coin selection. Interface: start/amount in, coin_out/done out.
- **Top level** owns the FSM, edge detection, the VEND_CYCLES counter and credit.

## Test plan
All scenarios use PRICE=15, VEND_CYCLES=4, CHANGE_GAP=2.
1. Assert reset with the clock running → all outputs 0, state=0. Release it → outputs remain idle.
2. Three r5 rises → credit_bcd 05, 10, 15. state=2 on the third rise; vend high for 4 cycles; then credit 00, IDLE, and coin_out never asserted.
3. Rises r5, r5, r2, r5 → credit 17 → VEND → credit 02 → a single coin_out=3'b010 pulse → IDLE.
4. r1, r2 and r5 rise in the same cycle → credit_bcd=08, state=1. cancel → coin_out 100, 010, 001 two cycles apart, credit 03→01→00 → IDLE.
5. r5 rise during VEND → reject pulses once and the change amount is unchanged. A coin that completes PRICE with cancel high in the same cycle → VEND, not a refund.
6. Drop reset between change pulses → outputs 0 immediately and no further coin_out. After release, the block accepts a new r1 → credit 01.
